// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc -- shared types and helpers for the ring NoC.
//
// Contents:
//   xy_t / xyWidth         router coordinates {y, x}; ring position = y*xMax + x
//   preamble_t             2-bit flit preamble {head, tail} in the flit MSBs
//   direction_t            one-hot output direction (dirNone when nothing valid)
//   noc_flow_control_t     ack/nack (stop) or credit-based backpressure
//   route_state_t          input-unit route FSM states
//   kHeadOfsFromMsb ...    flit field offsets, counted down from the flit MSB
//   xy2ring_pos()          coordinate -> linear ring position
//   ring_route()           output direction for a destination
//
// Configuration macro: NOC_RING_SHORTEST_PATH_EN
//   defined   -> bidirectional ring, shortest direction (ties go east)
//   undefined -> unidirectional ring, every non-local destination goes east
// -----------------------------------------------------------------------------
package noc;

    localparam int xMax    = 8;
    localparam int yMax    = 8;
    localparam int xWidth  = $clog2(xMax);
    localparam int yWidth  = $clog2(yMax);
    localparam int xyWidth = xWidth + yWidth;

    typedef struct packed {
        logic [yWidth-1:0] y;
        logic [xWidth-1:0] x;
    } xy_t;

    typedef struct packed {
        logic head;
        logic tail;
    } preamble_t;

    typedef enum logic [2:0] {
        dirNone = 3'b000,
        goEast  = 3'b001,
        goWest  = 3'b010,
        goLocal = 3'b100
    } direction_t;

    typedef enum logic {
        kFlowControlAckNack,
        kFlowControlCreditBased
    } noc_flow_control_t;

    typedef enum logic {
        RouteIdle,
        RouteLocked
    } route_state_t;

    // Field positions relative to the flit MSB, so they hold for any FlitWidth.
    localparam int kPreambleWidth  = $bits(preamble_t);
    localparam int kHeadOfsFromMsb = 0;
    localparam int kTailOfsFromMsb = 1;
    localparam int kDstOfsFromMsb  = kPreambleWidth;

    function automatic int xy2ring_pos(xy_t xy);
        return int'(xy.y) * xMax + int'(xy.x);
    endfunction

    function automatic direction_t ring_route(xy_t dst, xy_t src, int nodes);
`ifdef NOC_RING_SHORTEST_PATH_EN
        int d;
        if (dst == src) return goLocal;
        // Eastward hop count, folded into [0, nodes).
        d = xy2ring_pos(dst) - xy2ring_pos(src);
        if (d < 0) d = d + nodes;
        return (d <= nodes / 2) ? goEast : goWest;
`else
        if (dst == src) return goLocal;
        // A one-stop ring has nowhere else to go.
        return (nodes > 1) ? goEast : goLocal;
`endif
    endfunction

endpackage

// File: rtl/noc_ring_input_unit_fifo.sv
// -----------------------------------------------------------------------------
// noc_flit_fifo -- flit storage for one ring-router input.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   push, din         write a flit (ignored when full unless popping too)
//   pop               remove the head flit (ignored when empty)
//   dout              head-of-queue flit (no bypass; valid when !empty)
//   full, empty       occupancy flags
//   count             occupancy, log2(Depth)+1 bits
// -----------------------------------------------------------------------------
module noc_flit_fifo #(
    parameter int Depth     = 4,
    parameter int FlitWidth = 34
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [FlitWidth-1:0]   din,
    input  logic                   pop,
    output logic [FlitWidth-1:0]   dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(Depth):0] count
);

    localparam int PtrW = $clog2(Depth);
    localparam int CntW = PtrW + 1;

    logic [FlitWidth-1:0] mem [Depth];
    logic [PtrW-1:0]      wr_ptr, rd_ptr;
    logic                 do_push, do_pop;

    assign full    = (count == CntW'(Depth));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full queue still takes a write when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PtrW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PtrW'(1);
            count <= count + CntW'(do_push) - CntW'(do_pop);
        end
    end

    // Storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/noc_ring_input_unit.sv
// -----------------------------------------------------------------------------
// noc_ring_input_unit -- input unit for one ring-router port (East/West/Local).
//
// Buffers incoming flits, returns backpressure upstream and attaches an output
// direction to the queue-head flit. The route of a head flit is held for the
// body and tail of its packet.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   position_i      this router's coordinates (static)
//   data_in         incoming flit; data_void_in high = no flit
//   stop_out        ack/nack mode: registered stop (0 in credit mode)
//   credit_out      credit mode: one-cycle pulse per pop (0 in ack/nack mode)
//   data_out        head-of-queue flit; data_void_out high = queue empty
//   direction_out   one-hot route for data_out, dirNone when void/bad head
//   grant_in        allocator consumed data_out
//   overflow_o      sticky: a flit arrived with no room
//   route_err_o     sticky: a non-head flit reached the head with no open packet
//
// Configuration macro: NOC_RING_SHORTEST_PATH_EN (see package noc).
// -----------------------------------------------------------------------------
module noc_ring_input_unit
    import noc::*;
#(
    parameter int                FlitWidth   = 34,
    parameter int                Depth       = 4,
    parameter int                RingNodes   = 64,
    parameter noc_flow_control_t FlowControl = kFlowControlCreditBased
) (
    input  logic                 clk,
    input  logic                 rst,
    input  xy_t                  position_i,
    input  logic [FlitWidth-1:0] data_in,
    input  logic                 data_void_in,
    output logic                 stop_out,
    output logic                 credit_out,
    output logic [FlitWidth-1:0] data_out,
    output logic                 data_void_out,
    output direction_t           direction_out,
    input  logic                 grant_in,
    output logic                 overflow_o,
    output logic                 route_err_o
);

    localparam int              CntW      = $clog2(Depth) + 1;
    localparam logic [CntW-1:0] StopLevel = CntW'(Depth - 1);

    logic            full, empty;
    logic [CntW-1:0] count, count_next;
    logic            push, pop;
    logic            head_flit, tail_flit, bad_head;
    xy_t             dst_xy;
    direction_t      head_route;
    route_state_t    state_q, state_d;
    direction_t      locked_dir_q, locked_dir_d;

    // --- storage -------------------------------------------------------------
    assign push = !data_void_in && (!full || grant_in);
    // A bad head is dropped without waiting for the allocator.
    assign pop  = !empty && (grant_in || bad_head);

    noc_flit_fifo #(
        .Depth     (Depth),
        .FlitWidth (FlitWidth)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (data_in),
        .pop   (pop),
        .dout  (data_out),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign data_void_out = empty;
    assign count_next    = count + CntW'(push) - CntW'(pop);

    // --- head-flit decode ----------------------------------------------------
    assign head_flit  = data_out[FlitWidth-1-kHeadOfsFromMsb];
    assign tail_flit  = data_out[FlitWidth-1-kTailOfsFromMsb];
    assign dst_xy     = xy_t'(data_out[FlitWidth-1-kDstOfsFromMsb -: xyWidth]);
    assign head_route = ring_route(dst_xy, position_i, RingNodes);
    assign bad_head   = (state_q == RouteIdle) && !empty && !head_flit;

    // --- route FSM -----------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        locked_dir_d  = locked_dir_q;
        direction_out = dirNone;
        case (state_q)
            RouteIdle: begin
                if (!empty && head_flit) begin
                    direction_out = head_route;
                    // Single-flit packets never leave IDLE.
                    if (grant_in && !tail_flit) begin
                        state_d      = RouteLocked;
                        locked_dir_d = head_route;
                    end
                end
            end
            RouteLocked: begin
                if (!empty) begin
                    direction_out = locked_dir_q;
                    if (grant_in && tail_flit) state_d = RouteIdle;
                end
            end
            default: state_d = RouteIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= RouteIdle;
            locked_dir_q <= dirNone;
            stop_out     <= 1'b0;
            credit_out   <= 1'b0;
            overflow_o   <= 1'b0;
            route_err_o  <= 1'b0;
        end else begin
            state_q      <= state_d;
            locked_dir_q <= locked_dir_d;
            // Stop one entry early so a flit already in flight still fits.
            stop_out     <= (FlowControl == kFlowControlAckNack) && (count_next >= StopLevel);
            credit_out   <= (FlowControl == kFlowControlCreditBased) && pop;
            if (!data_void_in && !push) overflow_o  <= 1'b1;
            if (bad_head)               route_err_o <= 1'b1;
        end
    end

endmodule

// File: doc/noc_ring_input_unit.md
# noc_ring_input_unit

Parametrised input unit for one ring-router port. It buffers incoming flits in a FIFO and generates backpressure in either ack/nack (stop) or credit-based mode. For each head flit it computes the output direction on the bidirectional ring and holds that route until the packet's tail flit is granted. One instance sits behind each of the East, West and Local inputs of the ring router, ahead of the switch allocator.

## Interface
- FlitWidth, 34: flit width including the 2-bit `preamble_t` in the MSBs.
- Depth, 4: FIFO depth; power of 2, ≥2.
- RingNodes, 64: number of ring stops; must equal xMax*yMax.
- FlowControl, kFlowControlCreditBased: `noc_flow_control_t` mode.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- position_i  in  xy_t  this router's coordinates; static.
- data_in  in  FlitWidth  incoming flit.
- data_void_in  in  1  high = no flit this cycle.
- stop_out  out  1  ack/nack backpressure to upstream; tied 0 in credit mode.
- credit_out  out  1  one-cycle credit-return pulse; tied 0 in ack/nack mode.
- data_out  out  FlitWidth  head-of-queue flit.
- data_void_out  out  1  high = FIFO empty.
- direction_out  out  direction_t  one-hot route for data_out; all-zero when void.
- grant_in  in  1  allocator consumed data_out this cycle; ignored when void.
- overflow_o  out  1  sticky: a flit was written into a full FIFO.
- route_err_o  out  1  sticky: a non-head flit reached the queue head in IDLE.

## Operation
- **Write rule.** A flit is accepted when `!data_void_in` and (count<Depth or grant_in). Otherwise it is dropped and overflow_o is set.
- **Read rule.** grant_in with a non-empty FIFO pops one flit.
- **Ack/nack mode.** stop_out is registered. It is high in the cycle after occupancy ≥ Depth-1, which gives one cycle of slack for the upstream stage's reaction.
- **Credit mode.** credit_out pulses in the cycle after each pop. The upstream stage starts with Depth credits.
- **Ring position.** pos = y*xMax + x. The destination xy is in head-flit bits [FlitWidth-3 -: yWidth+xWidth].
- **Route computation.**
  - dst == own position → goLocal.
  - Otherwise d = (dst_pos - my_pos) mod RingNodes; d ≤ RingNodes/2 → goEast, else goWest. A tie goes east.
- **FSM.**
  - IDLE: direction_out is combinational from the queue-head flit.
  - On grant of a head flit without tail → LOCKED, with the direction registered.
  - LOCKED: direction_out = locked value. On grant of a tail flit → IDLE.
  - A head+tail (single-flit) packet stays in IDLE.
- **Route error.** A non-head flit at the queue head while IDLE: direction_out = 0, the flit is popped internally next cycle, and route_err_o is set.

## Timing
- Reset values: FIFO empty, state IDLE, stop_out=0, credit_out=0, data_void_out=1, direction_out=0, overflow_o=0, route_err_o=0.
- Latency: a flit accepted at edge N is visible on data_out/direction_out after edge N; there is no bypass path.
- Simultaneous write and grant when full: both take effect and count is unchanged.
- Wrap-around: pointers are log2(Depth) bits and wrap naturally; count is log2(Depth)+1 bits.
- Reset asserted mid-packet discards all contents and state immediately. Credits are not returned for discarded flits.

## Configuration
- NOC_RING_SHORTEST_PATH_EN defined: bidirectional shortest-path routing as described above.
- Undefined: unidirectional ring. Every non-local destination routes goEast; goWest is never produced.

## Structure
- Package `noc` gains:
  - `xyWidth`
  - function `xy2ring_pos(xy_t)`
  - function `ring_route(xy_t dst, xy_t src, int nodes)` returning `direction_t`, honouring the macro
  - flit field offset constants
- Sub-module `noc_flit_fifo` (Depth, FlitWidth; push/pop/full/empty/count) holds the storage. The route FSM and flow control stay in the top level.

## Test plan
- Position (1,0). Single-flit packets to (3,0), (7,7) and (1,4) → direction_out goEast, goWest (d=62), goEast (tie at d=32). With the macro undefined, (7,7) → goEast.
- Three-flit packet from (1,0) to (1,0) → goLocal on all three flits; state returns to IDLE after the tail grant; the next head is routed fresh.
- Ack/nack, Depth=4, grant_in=0, 4 back-to-back writes → stop_out high the cycle after the 3rd write; a 5th write is dropped and overflow_o=1.
- Credit mode: 4 writes, then 4 grants on consecutive cycles → 4 credit_out pulses, each one cycle after its grant; data_void_out=1 after the last grant.
- Body flit written into an empty queue → route_err_o=1, direction_out=0, flit discarded; the following head flit routes normally.
- rst low during the LOCKED body of a packet → all outputs at reset values; after release, a new head to (2,0) from (1,0) → goEast.
